// File: rtl/br_fifo_shared_pstatic_push_credit_sender_pkg.sv
// ============================================================================
// Module   : br_fifo_shared_pstatic_push_credit_sender_pkg
// Brief    : Shared helpers for the shared pseudo-static FIFO push credit sender.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package br_fifo_shared_pstatic_push_credit_sender_pkg;

    // Index width that never collapses to zero bits, so a single-entry
    // selection still has a usable port.
    function automatic int clamped_clog2(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage : br_fifo_shared_pstatic_push_credit_sender_pkg

`default_nettype wire

// File: rtl/br_fifo_shared_pstatic_push_credit_sender_counter.sv
// ============================================================================
// Module   : br_fifo_shared_pstatic_push_credit_sender_counter
// Brief    : Per-flow credit counter with withhold and floored available value.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module br_fifo_shared_pstatic_push_credit_sender_counter #(
    parameter int MAX_CREDIT = 3,
    localparam int COUNT_W = $clog2(MAX_CREDIT + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               incr_i,
    input  logic               decr_i,
    input  logic [COUNT_W-1:0] initial_i,
    input  logic [COUNT_W-1:0] withhold_i,
    output logic [COUNT_W-1:0] count_o,
    output logic [COUNT_W-1:0] available_o
);

    localparam logic [COUNT_W:0] c_MAX_COUNT = (COUNT_W + 1)'(MAX_CREDIT);

    logic [COUNT_W-1:0] count_q;
    logic [COUNT_W-1:0] count_d;
    logic [COUNT_W:0]   w_count_next;

    // One extra bit so an over-return is visible instead of wrapping.
    assign w_count_next = {1'b0, count_q}
                        + {{COUNT_W{1'b0}}, incr_i}
                        - {{COUNT_W{1'b0}}, decr_i};
    assign count_d      = w_count_next[COUNT_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= initial_i;
        end else begin
            count_q <= count_d;
        end
    end

    // Credits returned this cycle are not yet in count_q, so they cannot be spent.
    always_comb begin
        available_o = '0;
        if (count_q > withhold_i) begin
            available_o = count_q - withhold_i;
        end
    end

    assign count_o = count_q;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (w_count_next <= c_MAX_COUNT)
            else $error("credit counter overflow: next=%0d max=%0d", w_count_next, MAX_CREDIT);
        end
    end
`endif

endmodule : br_fifo_shared_pstatic_push_credit_sender_counter

`default_nettype wire

// File: rtl/br_fifo_shared_pstatic_push_credit_sender.sv
// ============================================================================
// Module   : br_fifo_shared_pstatic_push_credit_sender
// Brief    : Round-robin credit-based sender feeding the shared FIFO push port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module br_fifo_shared_pstatic_push_credit_sender
    import br_fifo_shared_pstatic_push_credit_sender_pkg::*;
#(
    parameter int NUM_FIFOS                     = 2,
    parameter int WIDTH                         = 1,
    parameter int MAX_CREDIT                    = 3,
    parameter bit REGISTER_PUSH_OUTPUTS         = 1'b1,
    parameter bit ENABLE_ASSERT_FINAL_NOT_VALID = 1'b1,
    localparam int FIFO_ID_W = clamped_clog2(NUM_FIFOS),
    localparam int COUNT_W   = $clog2(MAX_CREDIT + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_FIFOS-1:0]         src_valid_i,
    output logic [NUM_FIFOS-1:0]         src_ready_o,
    input  logic [NUM_FIFOS*WIDTH-1:0]   src_data_i,
    output logic                         push_sender_in_reset_o,
    input  logic                         push_receiver_in_reset_i,
    output logic [NUM_FIFOS-1:0]         push_credit_stall_o,
    input  logic [NUM_FIFOS-1:0]         push_credit_i,
    output logic                         push_valid_o,
    output logic [WIDTH-1:0]             push_data_o,
    output logic [FIFO_ID_W-1:0]         push_fifo_id_o,
    input  logic [NUM_FIFOS-1:0]         credit_stall_i,
    input  logic [NUM_FIFOS*COUNT_W-1:0] credit_initial_i,
    input  logic [NUM_FIFOS*COUNT_W-1:0] credit_withhold_i,
    output logic [NUM_FIFOS*COUNT_W-1:0] credit_count_o,
    output logic [NUM_FIFOS*COUNT_W-1:0] credit_available_o
);

    logic                 w_in_reset;
    logic [NUM_FIFOS-1:0] w_eligible;
    logic [NUM_FIFOS-1:0] w_grant;
    logic                 w_grant_any;
    logic [FIFO_ID_W-1:0] w_grant_id;
    logic [WIDTH-1:0]     w_push_data;
    logic [FIFO_ID_W-1:0] ptr_q;
    logic [FIFO_ID_W-1:0] ptr_d;
    int                   w_idx;
    int                   w_nxt;

    assign w_in_reset             = rst | push_receiver_in_reset_i;
    assign push_sender_in_reset_o = rst;
    assign push_credit_stall_o    = credit_stall_i | {NUM_FIFOS{rst}};

    for (genvar i = 0; i < NUM_FIFOS; i++) begin : g_flow
        br_fifo_shared_pstatic_push_credit_sender_counter #(
            .MAX_CREDIT (MAX_CREDIT)
        ) u_counter (
            .clk         (clk),
            .rst         (w_in_reset),
            .incr_i      (push_credit_i[i]),
            .decr_i      (w_grant[i]),
            .initial_i   (credit_initial_i[i*COUNT_W +: COUNT_W]),
            .withhold_i  (credit_withhold_i[i*COUNT_W +: COUNT_W]),
            .count_o     (credit_count_o[i*COUNT_W +: COUNT_W]),
            .available_o (credit_available_o[i*COUNT_W +: COUNT_W])
        );

        assign w_eligible[i] = src_valid_i[i]
                             && (credit_available_o[i*COUNT_W +: COUNT_W] != '0)
                             && !w_in_reset;
    end

    // Round-robin: scan from ptr_q, first eligible flow wins; pointer moves past it.
    always_comb begin
        w_grant     = '0;
        w_grant_any = 1'b0;
        w_grant_id  = '0;
        w_idx       = 0;
        w_nxt       = 0;
        ptr_d       = ptr_q;
        for (int k = 0; k < NUM_FIFOS; k++) begin
            w_idx = int'(ptr_q) + k;
            if (w_idx >= NUM_FIFOS) begin
                w_idx = w_idx - NUM_FIFOS;
            end
            if (!w_grant_any && w_eligible[w_idx]) begin
                w_grant_any     = 1'b1;
                w_grant[w_idx]  = 1'b1;
                w_grant_id      = FIFO_ID_W'(w_idx);
            end
        end
        if (w_grant_any) begin
            w_nxt = int'(w_grant_id) + 1;
            if (w_nxt >= NUM_FIFOS) begin
                w_nxt = 0;
            end
            ptr_d = FIFO_ID_W'(w_nxt);
        end
    end

    always_ff @(posedge clk) begin
        if (w_in_reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    always_comb begin
        w_push_data = '0;
        for (int i = 0; i < NUM_FIFOS; i++) begin
            if (w_grant[i]) begin
                w_push_data = src_data_i[i*WIDTH +: WIDTH];
            end
        end
    end

    assign src_ready_o = w_grant;

    if (REGISTER_PUSH_OUTPUTS) begin : g_push_reg
        logic                 push_valid_q;
        logic [WIDTH-1:0]     push_data_q;
        logic [FIFO_ID_W-1:0] push_fifo_id_q;

        always_ff @(posedge clk) begin
            if (w_in_reset) begin
                push_valid_q <= 1'b0;
            end else begin
                push_valid_q <= w_grant_any;
            end
        end

        // Payload is only meaningful alongside valid, so it carries no reset.
        always_ff @(posedge clk) begin
            if (w_grant_any) begin
                push_data_q    <= w_push_data;
                push_fifo_id_q <= w_grant_id;
            end
        end

        assign push_valid_o   = push_valid_q;
        assign push_data_o    = push_data_q;
        assign push_fifo_id_o = push_fifo_id_q;
    end else begin : g_push_comb
        assign push_valid_o   = w_grant_any;
        assign push_data_o    = w_push_data;
        assign push_fifo_id_o = w_grant_id;
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rst) begin
            assert (push_credit_i == '0)
            else $error("push_credit asserted while sender in reset: %b", push_credit_i);
        end
    end

    if (ENABLE_ASSERT_FINAL_NOT_VALID) begin : g_final_check
        final begin
            assert (src_valid_i == '0)
            else $error("src_valid still asserted at end of test: %b", src_valid_i);
            assert (push_valid_o == 1'b0)
            else $error("push_valid still asserted at end of test");
            assert (credit_count_o == credit_initial_i)
            else $error("credit_count %h differs from credit_initial %h at end of test",
                        credit_count_o, credit_initial_i);
        end
    end
`endif

endmodule : br_fifo_shared_pstatic_push_credit_sender

`default_nettype wire

// File: tb/tb_br_fifo_shared_pstatic_push_credit_sender.sv
// ============================================================================
// Module   : tb_br_fifo_shared_pstatic_push_credit_sender
// Brief    : Directed table plus randomized run against a behavioural credit model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_br_fifo_shared_pstatic_push_credit_sender;

    localparam int N    = 2;
    localparam int W    = 8;
    localparam int MAXC = 3;
    localparam int CW   = 2;
    localparam int NV   = 26;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     src_valid;
    logic [N-1:0]     src_ready;
    logic [N*W-1:0]   src_data;
    logic             sender_in_reset;
    logic             recv_rst;
    logic [N-1:0]     credit_stall_out;
    logic [N-1:0]     push_credit;
    logic             push_valid;
    logic [W-1:0]     push_data;
    logic [0:0]       push_fifo_id;
    logic [N-1:0]     credit_stall;
    logic [N*CW-1:0]  credit_initial;
    logic [N*CW-1:0]  credit_withhold;
    logic [N*CW-1:0]  credit_count;
    logic [N*CW-1:0]  credit_available;

    always #5 clk = ~clk;

    br_fifo_shared_pstatic_push_credit_sender #(
        .NUM_FIFOS                     (N),
        .WIDTH                         (W),
        .MAX_CREDIT                    (MAXC),
        .REGISTER_PUSH_OUTPUTS         (1'b1),
        .ENABLE_ASSERT_FINAL_NOT_VALID (1'b1)
    ) dut (
        .clk                      (clk),
        .rst                      (rst),
        .src_valid_i              (src_valid),
        .src_ready_o              (src_ready),
        .src_data_i               (src_data),
        .push_sender_in_reset_o   (sender_in_reset),
        .push_receiver_in_reset_i (recv_rst),
        .push_credit_stall_o      (credit_stall_out),
        .push_credit_i            (push_credit),
        .push_valid_o             (push_valid),
        .push_data_o              (push_data),
        .push_fifo_id_o           (push_fifo_id),
        .credit_stall_i           (credit_stall),
        .credit_initial_i         (credit_initial),
        .credit_withhold_i        (credit_withhold),
        .credit_count_o           (credit_count),
        .credit_available_o       (credit_available)
    );

    typedef struct {
        logic       rst;
        logic [1:0] sv;
        logic [1:0] cr;
        logic [1:0] wh1;
        logic [1:0] ready;
        logic       pv;
        logic       pid;
        logic [1:0] c0;
        logic [1:0] c1;
    } vec_t;

    vec_t tbl [NV];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: credits per flow, next flow to favour, pending registered push.
    int m_cnt [N];
    int m_rr;
    int m_win;
    bit m_pv;
    int m_pd;
    int m_pid;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int avail(input int c, input int wh);
        return (c > wh) ? c - wh : 0;
    endfunction

    task automatic model_pick();
        m_win = -1;
        if (!(rst || recv_rst)) begin
            for (int k = 0; k < N; k++) begin
                int idx = (m_rr + k) % N;
                if (m_win < 0 && src_valid[idx]
                    && avail(m_cnt[idx], int'(credit_withhold[idx*CW +: CW])) > 0) begin
                    m_win = idx;
                end
            end
        end
    endtask

    task automatic model_check();
        chk("src_ready", 32'(src_ready), (m_win >= 0) ? (32'd1 << m_win) : 32'd0);
        chk("push_valid", 32'(push_valid), 32'(m_pv));
        if (m_pv) begin
            chk("push_data", 32'(push_data), 32'(m_pd));
            chk("push_fifo_id", 32'(push_fifo_id), 32'(m_pid));
        end
        for (int i = 0; i < N; i++) begin
            chk($sformatf("count%0d", i), 32'(credit_count[i*CW +: CW]), 32'(m_cnt[i]));
            chk($sformatf("available%0d", i), 32'(credit_available[i*CW +: CW]),
                32'(avail(m_cnt[i], int'(credit_withhold[i*CW +: CW]))));
        end
        chk("sender_in_reset", 32'(sender_in_reset), 32'(rst));
        chk("credit_stall_out", 32'(credit_stall_out), 32'(credit_stall | {N{rst}}));
    endtask

    task automatic model_edge();
        if (rst || recv_rst) begin
            for (int i = 0; i < N; i++) m_cnt[i] = int'(credit_initial[i*CW +: CW]);
            m_rr = 0;
            m_pv = 1'b0;
        end else begin
            for (int i = 0; i < N; i++) begin
                m_cnt[i] = m_cnt[i] + int'(push_credit[i]) - ((m_win == i) ? 1 : 0);
            end
            m_pv = (m_win >= 0);
            if (m_win >= 0) begin
                m_pd  = int'(src_data[m_win*W +: W]);
                m_pid = m_win;
                m_rr  = (m_win + 1) % N;
            end
        end
    endtask

    task automatic step_a();
        model_pick();
        @(negedge clk);
        model_check();
    endtask

    task automatic step_b();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        //        rst   sv     cr     wh1  | ready  pv    pid   c0     c1
        tbl = '{
            '{1'b1, 2'b00, 2'b00, 2'd0, 2'b00, 1'b0, 1'b0, 2'd0, 2'd0},
            '{1'b0, 2'b00, 2'b10, 2'd0, 2'b00, 1'b0, 1'b0, 2'd0, 2'd0},
            '{1'b0, 2'b00, 2'b10, 2'd0, 2'b00, 1'b0, 1'b0, 2'd0, 2'd1},
            '{1'b0, 2'b00, 2'b10, 2'd0, 2'b00, 1'b0, 1'b0, 2'd0, 2'd2},
            '{1'b0, 2'b00, 2'b00, 2'd0, 2'b00, 1'b0, 1'b0, 2'd0, 2'd3},
            '{1'b0, 2'b10, 2'b00, 2'd0, 2'b10, 1'b0, 1'b0, 2'd0, 2'd3},
            '{1'b0, 2'b00, 2'b00, 2'd0, 2'b00, 1'b1, 1'b1, 2'd0, 2'd2},
            '{1'b0, 2'b00, 2'b01, 2'd0, 2'b00, 1'b0, 1'b0, 2'd0, 2'd2},
            '{1'b0, 2'b00, 2'b01, 2'd0, 2'b00, 1'b0, 1'b0, 2'd1, 2'd2},
            '{1'b0, 2'b11, 2'b00, 2'd0, 2'b01, 1'b0, 1'b0, 2'd2, 2'd2},
            '{1'b0, 2'b11, 2'b00, 2'd0, 2'b10, 1'b1, 1'b0, 2'd1, 2'd2},
            '{1'b0, 2'b11, 2'b00, 2'd0, 2'b01, 1'b1, 1'b1, 2'd1, 2'd1},
            '{1'b0, 2'b11, 2'b00, 2'd0, 2'b10, 1'b1, 1'b0, 2'd0, 2'd1},
            '{1'b0, 2'b11, 2'b00, 2'd0, 2'b00, 1'b1, 1'b1, 2'd0, 2'd0},
            '{1'b0, 2'b00, 2'b00, 2'd0, 2'b00, 1'b0, 1'b0, 2'd0, 2'd0},
            '{1'b0, 2'b00, 2'b10, 2'd1, 2'b00, 1'b0, 1'b0, 2'd0, 2'd0},
            '{1'b0, 2'b10, 2'b00, 2'd1, 2'b00, 1'b0, 1'b0, 2'd0, 2'd1},
            '{1'b0, 2'b10, 2'b00, 2'd0, 2'b10, 1'b0, 1'b0, 2'd0, 2'd1},
            '{1'b0, 2'b00, 2'b00, 2'd0, 2'b00, 1'b1, 1'b1, 2'd0, 2'd0},
            '{1'b0, 2'b00, 2'b01, 2'd0, 2'b00, 1'b0, 1'b0, 2'd0, 2'd0},
            '{1'b0, 2'b00, 2'b01, 2'd0, 2'b00, 1'b0, 1'b0, 2'd1, 2'd0},
            '{1'b0, 2'b01, 2'b01, 2'd0, 2'b01, 1'b0, 1'b0, 2'd2, 2'd0},
            '{1'b0, 2'b00, 2'b00, 2'd0, 2'b00, 1'b1, 1'b0, 2'd2, 2'd0},
            '{1'b0, 2'b01, 2'b00, 2'd0, 2'b01, 1'b0, 1'b0, 2'd2, 2'd0},
            '{1'b1, 2'b01, 2'b00, 2'd0, 2'b00, 1'b1, 1'b0, 2'd1, 2'd0},
            '{1'b0, 2'b01, 2'b00, 2'd0, 2'b00, 1'b0, 1'b0, 2'd0, 2'd0}
        };

        rst             = 1'b1;
        recv_rst        = 1'b0;
        src_valid       = '0;
        push_credit     = '0;
        credit_stall    = '0;
        credit_initial  = '0;
        credit_withhold = '0;
        src_data        = {8'hB1, 8'hA0};
        m_win           = -1;
        @(posedge clk);
        model_edge();
        #1;

        for (int r = 0; r < NV; r++) begin
            rst             = tbl[r].rst;
            src_valid       = tbl[r].sv;
            push_credit     = tbl[r].cr;
            credit_withhold = {tbl[r].wh1, 2'd0};
            step_a();
            chk($sformatf("tbl%0d_ready", r), 32'(src_ready), 32'(tbl[r].ready));
            chk($sformatf("tbl%0d_pv", r), 32'(push_valid), 32'(tbl[r].pv));
            if (tbl[r].pv) chk($sformatf("tbl%0d_pid", r), 32'(push_fifo_id), 32'(tbl[r].pid));
            chk($sformatf("tbl%0d_c0", r), 32'(credit_count[1:0]), 32'(tbl[r].c0));
            chk($sformatf("tbl%0d_c1", r), 32'(credit_count[3:2]), 32'(tbl[r].c1));
            step_b();
        end

        for (int c = 0; c < 3000; c++) begin
            rst          = ($urandom_range(0, 59) == 0);
            recv_rst     = ($urandom_range(0, 79) == 0);
            src_valid    = N'($urandom);
            src_data     = (N*W)'($urandom);
            credit_stall = N'($urandom);
            if ($urandom_range(0, 15) == 0) begin
                credit_withhold = {2'($urandom_range(0, 1)), 2'($urandom_range(0, 2))};
            end
            if (rst) begin
                credit_initial = {2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            end
            for (int i = 0; i < N; i++) begin
                push_credit[i] = !rst && (m_cnt[i] < MAXC) && ($urandom_range(0, 1) == 1);
            end
            step_a();
            step_b();
        end

        rst          = 1'b1;
        recv_rst     = 1'b0;
        src_valid    = '0;
        push_credit  = '0;
        credit_stall = '0;
        step_a();
        step_b();
        rst = 1'b0;
        step_a();
        step_b();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_br_fifo_shared_pstatic_push_credit_sender

`default_nettype wire
